// File: rtl/lo_pkg.sv
// Shared types and constants for the LF pass-through block.
package lo_pkg;

  // Drive controller states. The encoding is fixed so it can be read on a debug probe.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TRIP  = 2'd2
  } lo_state_e;

  // Default driver-enable mask for pwr_oe4..pwr_oe1 while driving.
  localparam logic [3:0] LO_OE_MASK_DEFAULT = 4'b1011;

  // Driver enables for a given state. Only DRIVE lets any driver turn on.
  function automatic logic [3:0] drive_oe(input lo_state_e st, input logic [3:0] mask);
    drive_oe = (st == ST_DRIVE) ? mask : 4'b0000;
  endfunction

endpackage

// File: rtl/lo_glitch_filter.sv
// Input synchroniser followed by an optional glitch filter.
// The filtered output follows the synchronised input only after the two have
// disagreed on GLITCH_CYC+1 consecutive clock edges, so a pulse must last more
// than GLITCH_CYC cycles to get through. GLITCH_CYC=0 turns the filter off
// and the output is the synchroniser output with no extra delay.
// SYNC_STAGES must be at least 2.
module lo_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   lo_s;

  // Next value of the synchroniser chain: shift the raw input in at bit 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign lo_s = sync_q[SYNC_STAGES-1];

  if (GLITCH_CYC == 0) begin : g_bypass
    assign filt = lo_s;
  end else begin : g_filter
    localparam int CW = $clog2(GLITCH_CYC + 1);
    localparam logic [CW-1:0] STAB_MAX = CW'(GLITCH_CYC);

    logic [CW-1:0] stab_q;
    logic [CW-1:0] stab_d;
    logic          filt_q;
    logic          filt_d;

    // Count consecutive disagreeing cycles; commit the new level once the
    // count has already reached GLITCH_CYC and the disagreement persists.
    always_comb begin
      stab_d = stab_q;
      filt_d = filt_q;
      if (lo_s == filt_q) begin
        stab_d = '0;
      end else if (stab_q == STAB_MAX) begin
        filt_d = lo_s;
        stab_d = '0;
      end else begin
        stab_d = stab_q + CW'(1);
      end
    end

    // Stability counter and filtered level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stab_q <= '0;
        filt_q <= 1'b0;
      end else begin
        stab_q <= stab_d;
        filt_q <= filt_d;
      end
    end

    assign filt = filt_q;
  end

endmodule

// File: rtl/lo_passthru_gen.sv
// LF pass-through: the ARM keys the antenna through ssp_dout and hears the
// comparator through ssp_din. Adds a local carrier divider, synchronised and
// glitch-filtered paths, a driver-enable mask, a drive watchdog and a
// saturating edge counter for the listen window.
//
// Handshake: there is no valid/ready pair here; ssp_dout is a level request,
// sampled through the synchroniser, and the drivers follow it while enabled.
module lo_passthru_gen
  import lo_pkg::*;
#(
  parameter int         DIV_W       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         GLITCH_CYC  = 3,
  parameter int         WDT_W       = 16,
  parameter int         CNT_W       = 12,
  parameter logic [3:0] OE_MASK     = LO_OE_MASK_DEFAULT
) (
  input  logic             pck0,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic [WDT_W-1:0] wdt_limit,
  input  logic             enable,
  input  logic             ssp_dout,
  input  logic             cross_lo,
  output logic             ssp_din,
  output logic             pwr_lo,
  output logic             pwr_hi,
  output logic             pwr_oe1,
  output logic             pwr_oe2,
  output logic             pwr_oe3,
  output logic             pwr_oe4,
  output logic             adc_clk,
  output logic             wdt_trip,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             debug
);

  logic dout_s;
  logic filt;

  // ssp_dout only needs synchronising; the filter stage is bypassed.
  lo_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .GLITCH_CYC  (0)
  ) u_dout_sync (
    .clk     (pck0),
    .rst     (rst),
    .d_async (ssp_dout),
    .filt    (dout_s)
  );

  // cross_lo is synchronised and glitch filtered before anyone sees it.
  lo_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .GLITCH_CYC  (GLITCH_CYC)
  ) u_lo_filter (
    .clk     (pck0),
    .rst     (rst),
    .d_async (cross_lo),
    .filt    (filt)
  );

  // ---------------------------------------------------------------------
  // Carrier divider. The divisor is latched at each wrap so a change made
  // mid half-period never produces a short or long half-period.
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic             carrier_q, carrier_d;

  // Count up to the latched divisor, then wrap, toggle and relatch.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    div_lat_d = div_lat_q;
    carrier_d = carrier_q;
    if (div_cnt_q == div_lat_q) begin
      div_cnt_d = '0;
      carrier_d = ~carrier_q;
      div_lat_d = divisor;
    end
  end

  // Carrier divider registers.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      div_lat_q <= '0;
      carrier_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_lat_q <= div_lat_d;
      carrier_q <= carrier_d;
    end
  end

  // ---------------------------------------------------------------------
  // Drive FSM with watchdog.
  // ---------------------------------------------------------------------
  lo_state_e        state_q, state_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             wdt_on;
  logic             wdt_expire;

  assign wdt_on     = (wdt_limit != '0);
  assign wdt_expire = wdt_on && (wdt_q == (wdt_limit - WDT_W'(1)));

  // State register.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Dropping the request is checked before the watchdog so a
  // release on the expiry cycle returns to IDLE instead of tripping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && dout_s) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (!dout_s || !enable) state_d = ST_IDLE;
        else if (wdt_expire)    state_d = ST_TRIP;
      end
      ST_TRIP: begin
        if (!dout_s || !enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog count: cleared in IDLE, advances on each cycle that stays in DRIVE.
  always_comb begin
    wdt_d = wdt_q;
    if (state_q == ST_IDLE) begin
      wdt_d = '0;
    end else if ((state_q == ST_DRIVE) && (state_d == ST_DRIVE)) begin
      wdt_d = wdt_q + WDT_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Registered driver outputs, one cycle behind the state so they never
  // see combinational decode glitches. Async reset drops them at once.
  // ---------------------------------------------------------------------
  logic [3:0] oe_q, oe_d;
  logic       pwr_lo_q, pwr_lo_d;
  logic       trip_q, trip_d;

  // Output decode from the current state.
  always_comb begin
    oe_d     = drive_oe(state_q, OE_MASK);
    pwr_lo_d = (state_q == ST_DRIVE) && carrier_q;
    trip_d   = (state_q == ST_TRIP);
  end

  // Output registers.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      oe_q     <= 4'b0000;
      pwr_lo_q <= 1'b0;
      trip_q   <= 1'b0;
    end else begin
      oe_q     <= oe_d;
      pwr_lo_q <= pwr_lo_d;
      trip_q   <= trip_d;
    end
  end

  // ---------------------------------------------------------------------
  // Listen-window edge counter: rising edges of the filtered comparator
  // while idle, saturating, cleared as a new drive starts.
  // ---------------------------------------------------------------------
  logic             filt_prev_q, filt_prev_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             filt_rise;

  assign filt_rise = filt && !filt_prev_q;

  // Edge count update; the clear on drive entry takes priority.
  always_comb begin
    filt_prev_d = filt;
    edge_cnt_d  = edge_cnt_q;
    if ((state_q == ST_IDLE) && (state_d == ST_DRIVE)) begin
      edge_cnt_d = '0;
    end else if ((state_q == ST_IDLE) && filt_rise && (edge_cnt_q != {CNT_W{1'b1}})) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // Edge detector and counter registers.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      filt_prev_q <= 1'b0;
      edge_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_prev_d;
      edge_cnt_q  <= edge_cnt_d;
    end
  end

  assign ssp_din  = filt;
  assign debug    = filt;
  assign pwr_lo   = pwr_lo_q;
  assign pwr_hi   = 1'b0;
  assign adc_clk  = 1'b0;
  assign pwr_oe1  = oe_q[0];
  assign pwr_oe2  = oe_q[1];
  assign pwr_oe3  = oe_q[2];
  assign pwr_oe4  = oe_q[3];
  assign wdt_trip = trip_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_lo_passthru_gen.sv
// Bench for lo_passthru_gen: directed steps plus a randomized phase, with a
// behavioural reference model compared against every output on each cycle.
module tb_lo_passthru_gen;

  localparam int         GLITCH  = 3;
  localparam logic [3:0] OE_MASK = 4'b1011;
  localparam int         CNT_MAX = 4095;
  localparam int         M_IDLE  = 0;
  localparam int         M_DRIVE = 1;
  localparam int         M_TRIP  = 2;

  logic        pck0;
  logic        rst;
  logic [7:0]  divisor;
  logic [15:0] wdt_limit;
  logic        enable;
  logic        ssp_dout;
  logic        cross_lo;
  logic        ssp_din, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4;
  logic        adc_clk, wdt_trip, debug;
  logic [11:0] edge_cnt;

  int n_cmp = 0;
  int n_err = 0;

  lo_passthru_gen dut (
    .pck0      (pck0),
    .rst       (rst),
    .divisor   (divisor),
    .wdt_limit (wdt_limit),
    .enable    (enable),
    .ssp_dout  (ssp_dout),
    .cross_lo  (cross_lo),
    .ssp_din   (ssp_din),
    .pwr_lo    (pwr_lo),
    .pwr_hi    (pwr_hi),
    .pwr_oe1   (pwr_oe1),
    .pwr_oe2   (pwr_oe2),
    .pwr_oe3   (pwr_oe3),
    .pwr_oe4   (pwr_oe4),
    .adc_clk   (adc_clk),
    .wdt_trip  (wdt_trip),
    .edge_cnt  (edge_cnt),
    .debug     (debug)
  );

  // Clock
  initial begin
    pck0 = 1'b0;
    forever #5 pck0 = ~pck0;
  end

  // ---------------- reference model ----------------
  logic m_d1, m_d2, m_l1, m_l2;
  logic m_hist[$];
  logic m_filt, m_filt_prev;
  int   m_state, m_wdt, m_edges, m_since, m_half;
  logic m_car, m_pwr_lo, m_trip;
  logic [3:0] m_oe;

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_l1 = 0; m_l2 = 0;
    m_hist.delete();
    m_filt = 0; m_filt_prev = 0;
    m_state = M_IDLE; m_wdt = 0; m_edges = 0;
    m_since = 0; m_half = 1; m_car = 0;
    m_pwr_lo = 0; m_trip = 0; m_oe = 4'b0000;
  endtask

  // One clock edge of the model, from the documented behaviour.
  task automatic model_step();
    logic dout_s, lo_s, flip, rise, n_filt;
    int ns;
    dout_s = m_d2;
    lo_s   = m_l2;
    // Filter: flip once the last GLITCH+1 samples all disagree with the output.
    m_hist.push_back(lo_s);
    if (m_hist.size() > GLITCH + 1) void'(m_hist.pop_front());
    flip = (m_hist.size() == GLITCH + 1);
    foreach (m_hist[i]) if (m_hist[i] == m_filt) flip = 1'b0;
    n_filt = flip ? ~m_filt : m_filt;
    // Drive controller
    ns = m_state;
    if (m_state == M_IDLE) begin
      if (enable && dout_s) ns = M_DRIVE;
    end else if (m_state == M_DRIVE) begin
      if (!dout_s || !enable) ns = M_IDLE;
      else if (wdt_limit != 0 && m_wdt == int'(wdt_limit) - 1) ns = M_TRIP;
    end else begin
      if (!dout_s || !enable) ns = M_IDLE;
    end
    rise = m_filt && !m_filt_prev;
    if (m_state == M_IDLE && ns == M_DRIVE) m_edges = 0;
    else if (m_state == M_IDLE && rise && m_edges < CNT_MAX) m_edges++;
    if (m_state == M_IDLE) m_wdt = 0;
    else if (m_state == M_DRIVE && ns == M_DRIVE) m_wdt = (m_wdt + 1) % 65536;
    m_oe     = (m_state == M_DRIVE) ? OE_MASK : 4'b0000;
    m_pwr_lo = (m_state == M_DRIVE) && m_car;
    m_trip   = (m_state == M_TRIP);
    // Carrier: toggle after 'half' cycles, half taken from divisor at each toggle.
    m_since++;
    if (m_since == m_half) begin
      m_car   = ~m_car;
      m_since = 0;
      m_half  = int'(divisor) + 1;
    end
    m_state = ns;
    m_filt_prev = m_filt;
    m_filt = n_filt;
    m_d2 = m_d1; m_d1 = ssp_dout;
    m_l2 = m_l1; m_l1 = cross_lo;
  endtask

  always @(posedge pck0 or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Scoreboard: every output against the model on each falling edge.
  always @(negedge pck0) begin
    logic [21:0] obs, exp;
    obs = {ssp_din, debug, pwr_lo, pwr_hi, pwr_oe4, pwr_oe3, pwr_oe2, pwr_oe1,
           adc_clk, wdt_trip, edge_cnt};
    exp = {m_filt, m_filt, m_pwr_lo, 1'b0, m_oe, 1'b0, m_trip, 12'(m_edges)};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL cycle_outputs t=%0t observed=%h expected=%h", $time, obs, exp);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oe_vec();
    return {pwr_oe4, pwr_oe3, pwr_oe2, pwr_oe1};
  endfunction

  // Cycles until pwr_lo next changes, bounded.
  task automatic wait_toggle(output int n, output logic ok);
    logic prev;
    prev = pwr_lo;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge pck0);
      n++;
      if (pwr_lo !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_lo(input int hi, input int lo);
    cross_lo = 1'b1;
    repeat (hi) @(negedge pck0);
    cross_lo = 1'b0;
    repeat (lo) @(negedge pck0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n, cnt, hi_cnt, drive_cnt;
    logic ok, found, trip_seen;

    rst = 1'b1; divisor = 8'd4; wdt_limit = 16'd0; enable = 1'b1;
    ssp_dout = 1'b1; cross_lo = 1'b0;
    repeat (3) @(negedge pck0);
    chk("reset_outputs", {pwr_lo, oe_vec(), wdt_trip, ssp_din}, 0);
    chk("reset_edge_cnt", edge_cnt, 0);

    // Release with a drive request already present.
    rst = 1'b0;
    repeat (3) @(negedge pck0);
    chk("oe_before_4th_edge", oe_vec(), 4'b0000);
    @(negedge pck0);
    chk("oe_at_4th_edge", oe_vec(), 4'b1011);

    // Carrier half periods, then a divisor change mid half-period.
    wait_toggle(n, ok);
    wait_toggle(n, ok); chk("half_div4_a", n, 5);
    wait_toggle(n, ok); chk("half_div4_b", n, 5);
    divisor = 8'd1;
    wait_toggle(n, ok); chk("half_old_completes", n, 5);
    wait_toggle(n, ok); chk("half_div1_a", n, 2);
    wait_toggle(n, ok); chk("half_div1_b", n, 2);
    chk("toggle_timeout", ok, 1);

    // Watchdog: exactly 100 drive cycles then trip.
    ssp_dout = 1'b0;
    repeat (6) @(negedge pck0);
    wdt_limit = 16'd100;
    ssp_dout = 1'b1;
    cnt = 0; found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge pck0);
      if (wdt_trip === 1'b1) begin found = 1'b1; break; end
      if (pwr_oe1 === 1'b1) cnt++;
    end
    chk("wdt_trip_seen", found, 1);
    chk("wdt_drive_cycles", cnt, 100);
    chk("trip_drivers_off", {pwr_lo, oe_vec()}, 0);
    ssp_dout = 1'b0;
    repeat (3) @(negedge pck0);
    chk("trip_held_in_sync", wdt_trip, 1);
    @(negedge pck0);
    chk("trip_released", wdt_trip, 0);
    ssp_dout = 1'b1;
    repeat (4) @(negedge pck0);
    chk("drive_resumes", oe_vec(), 4'b1011);

    // Request drops on the same cycle the watchdog would expire.
    ssp_dout = 1'b0;
    repeat (6) @(negedge pck0);
    ssp_dout = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pck0);
      if (pwr_oe1 === 1'b1) begin found = 1'b1; break; end
    end
    chk("simul_drive_start", found, 1);
    cnt = 1; trip_seen = 1'b0;
    for (int i = 0; i < 96; i++) begin
      @(negedge pck0);
      if (pwr_oe1 === 1'b1) cnt++;
    end
    ssp_dout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pck0);
      if (pwr_oe1 === 1'b1) cnt++;
      if (wdt_trip === 1'b1) trip_seen = 1'b1;
    end
    chk("simul_no_trip", trip_seen, 0);
    chk("simul_drive_cycles", cnt, 100);

    // Glitch filter: pulses of 1..4 cycles.
    repeat (10) @(negedge pck0);
    for (int k = 1; k <= 4; k++) begin
      pulse_lo(k, 0);
      hi_cnt = 0;
      for (int i = 0; i < 14; i++) begin
        @(negedge pck0);
        if (ssp_din === 1'b1) hi_cnt++;
      end
      chk($sformatf("glitch_pulse_%0d", k), hi_cnt, (k > GLITCH) ? k : 0);
    end

    // Edge counter: clear via a drive, count five pulses, clear again.
    ssp_dout = 1'b1;
    repeat (8) @(negedge pck0);
    ssp_dout = 1'b0;
    repeat (6) @(negedge pck0);
    chk("edge_cnt_cleared", edge_cnt, 0);
    for (int p = 0; p < 5; p++) pulse_lo(6, 6);
    repeat (10) @(negedge pck0);
    chk("edge_cnt_five", edge_cnt, 5);
    ssp_dout = 1'b1;
    repeat (4) @(negedge pck0);
    chk("edge_cnt_drive_clear", edge_cnt, 0);
    ssp_dout = 1'b0;
    repeat (6) @(negedge pck0);
    for (int p = 0; p < 4100; p++) pulse_lo(5, 5);
    repeat (10) @(negedge pck0);
    chk("edge_cnt_saturate", edge_cnt, CNT_MAX);

    // Randomized phase, checked cycle by cycle against the model.
    wdt_limit = 16'($urandom_range(5, 40));
    drive_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge pck0);
      if (pwr_oe1 === 1'b1) drive_cnt++;
      if ($urandom_range(0, 9) == 0) ssp_dout = ~ssp_dout;
      if ($urandom_range(0, 2) == 0) cross_lo = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) divisor = 8'($urandom_range(0, 6));
    end
    chk("random_drive_seen", (drive_cnt > 0), 1);

    // Asynchronous reset while driving with pwr_lo high.
    enable = 1'b1; wdt_limit = 16'd0; cross_lo = 1'b0; divisor = 8'd3;
    ssp_dout = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pck0);
      if (pwr_lo === 1'b1) begin found = 1'b1; break; end
    end
    chk("pwr_lo_high_before_rst", found, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_clear", {pwr_lo, oe_vec(), wdt_trip}, 0);
    repeat (2) @(negedge pck0);
    rst = 1'b0;
    repeat (5) @(negedge pck0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
